// File: rtl/gpio_handover.sv
// rtl/gpio_handover.sv - per-pin tristate blanking on GPIO owner handover
// Each pin holds its pad tristated for BLANK_CYCLES edges after its owner code last changed.
module gpio_handover #(
    parameter int NUM_PINS     = 38,
    parameter int SEL_W        = 4,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [NUM_PINS*SEL_W-1:0] pin_sel,
    input  logic [NUM_PINS-1:0]       mux_out,
    input  logic [NUM_PINS-1:0]       mux_oeb,
    output logic [NUM_PINS-1:0]       pad_out,
    output logic [NUM_PINS-1:0]       pad_oeb,
    output logic [NUM_PINS-1:0]       busy,
    output logic [NUM_PINS-1:0]       done,
    output logic [15:0]               handover_cnt
);

    typedef enum logic {IDLE, BLANK} state_t;

    localparam logic [7:0] RELOAD = 8'(BLANK_CYCLES - 1);

    logic [NUM_PINS-1:0] enter;

    for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
        state_t           state;
        logic [SEL_W-1:0] sel_q;
        logic [7:0]       cnt;
        logic             out_q;
        logic             oeb_q;
        logic             busy_q;
        logic             done_q;
        logic             change;
        logic             next_blank;

        assign change     = pin_sel[gi*SEL_W +: SEL_W] != sel_q;
        // Pad is forced off whenever the pin will be in BLANK after this edge.
        assign next_blank = change || (state == BLANK && cnt != 8'd0);
        assign enter[gi]  = change && (state == IDLE);

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                state  <= IDLE;
                sel_q  <= '0;
                cnt    <= '0;
                out_q  <= 1'b0;
                oeb_q  <= 1'b1;
                busy_q <= 1'b0;
                done_q <= 1'b0;
            end else begin
                out_q  <= ~next_blank & mux_out[gi];
                oeb_q  <= next_blank | mux_oeb[gi];
                busy_q <= next_blank;
                done_q <= 1'b0;
                if (change) begin
                    state <= BLANK;
                    cnt   <= RELOAD;
                    sel_q <= pin_sel[gi*SEL_W +: SEL_W];
                end else if (state == BLANK) begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
            end
        end

        assign pad_out[gi] = out_q;
        assign pad_oeb[gi] = oeb_q;
        assign busy[gi]    = busy_q;
        assign done[gi]    = done_q;
    end

    // Simultaneous entries on several pins are one handover event.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            handover_cnt <= '0;
        end else if (|enter && handover_cnt != 16'hFFFF) begin
            handover_cnt <= handover_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_gpio_handover.sv
// tb/tb_gpio_handover.sv - self-checking bench for gpio_handover
// Reference model tracks remaining blank cycles per pin from the handover rules.
module tb_gpio_handover;

    localparam int N = 38;
    localparam int W = 4;
    localparam int B = 8;

    logic           clk = 1'b0;
    logic           nrst;
    logic [N*W-1:0] pin_sel;
    logic [N-1:0]   mux_out;
    logic [N-1:0]   mux_oeb;
    logic [N-1:0]   pad_out;
    logic [N-1:0]   pad_oeb;
    logic [N-1:0]   busy;
    logic [N-1:0]   done;
    logic [15:0]    handover_cnt;

    gpio_handover #(.NUM_PINS(N), .SEL_W(W), .BLANK_CYCLES(B)) dut (
        .clk(clk), .nrst(nrst), .pin_sel(pin_sel), .mux_out(mux_out), .mux_oeb(mux_oeb),
        .pad_out(pad_out), .pad_oeb(pad_oeb), .busy(busy), .done(done), .handover_cnt(handover_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int           m_sel [N];
    int           m_rem [N];
    logic [N-1:0] m_out, m_oeb, m_busy, m_done;
    int           m_cnt;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sel[i] = 0;
            m_rem[i] = 0;
        end
        m_out  = '0;
        m_oeb  = '1;
        m_busy = '0;
        m_done = '0;
        m_cnt  = 0;
    endtask

    task automatic model_edge();
        bit any_enter = 0;
        for (int i = 0; i < N; i++) begin
            int  s = int'(pin_sel[i*W +: W]);
            bit  d = 0;
            if (s != m_sel[i]) begin
                if (m_rem[i] == 0) any_enter = 1;
                m_rem[i] = B;
                m_sel[i] = s;
            end else if (m_rem[i] > 0) begin
                m_rem[i]--;
                if (m_rem[i] == 0) d = 1;
            end
            m_busy[i] = (m_rem[i] > 0);
            m_done[i] = d;
            m_oeb[i]  = m_busy[i] ? 1'b1 : mux_oeb[i];
            m_out[i]  = m_busy[i] ? 1'b0 : mux_out[i];
        end
        if (any_enter && m_cnt < 65535) m_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (nrst) model_edge();
        @(negedge clk);
    endtask

    task automatic rand_mux();
        mux_out = N'({$urandom(), $urandom()});
        mux_oeb = N'({$urandom(), $urandom()});
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        nrst    = 1'b0;
        pin_sel = '0;
        mux_oeb = '0;
        mux_out = 38'h15;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (pad_oeb !== {N{1'b1}} || pad_out !== '0 || busy !== '0 || done !== '0 || handover_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_hold oeb=%h out=%h busy=%h done=%h cnt=%0d want oeb=all1 rest=0", pad_oeb, pad_out, busy, done, handover_cnt);
        end
        @(negedge clk);
        nrst = 1'b1;
        tick();
        total++;
        if (pad_oeb !== '0 || pad_out !== 38'h15 || busy !== '0 || done !== '0 || handover_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_release oeb=%h out=%h busy=%h cnt=%0d want oeb=0 out=15 busy=0 cnt=0", pad_oeb, pad_out, busy, handover_cnt);
        end
    endtask

    task automatic test_single();
        int bc = 0, dc = 0;
        pin_sel[3*W +: W] = 4'd2;
        for (int c = 0; c < 12; c++) begin
            rand_mux();
            tick();
            bc += int'(busy[3]);
            dc += int'(done[3]);
            total++;
            if ({pad_out, pad_oeb, busy, done} !== {m_out, m_oeb, m_busy, m_done} || handover_cnt !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL single c=%0d out=%h/%h oeb=%h/%h busy=%h/%h done=%h/%h cnt=%0d/%0d", c, pad_out, m_out, pad_oeb, m_oeb, busy, m_busy, done, m_done, handover_cnt, m_cnt);
            end
        end
        total++;
        if (bc != B || dc != 1 || handover_cnt !== 16'd1) begin
            bad++;
            $display("FAIL single_summary busy_cycles=%0d done=%0d cnt=%0d want 8 1 1", bc, dc, handover_cnt);
        end
    endtask

    task automatic test_restart();
        int bc = 0, dc = 0;
        pin_sel[5*W +: W] = 4'd1;
        for (int c = 0; c < 15; c++) begin
            if (c == 3) pin_sel[5*W +: W] = 4'd4;
            rand_mux();
            tick();
            bc += int'(busy[5]);
            dc += int'(done[5]);
            total++;
            if ({pad_out, pad_oeb, busy, done} !== {m_out, m_oeb, m_busy, m_done} || handover_cnt !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL restart c=%0d out=%h/%h oeb=%h/%h busy=%h/%h done=%h/%h cnt=%0d/%0d", c, pad_out, m_out, pad_oeb, m_oeb, busy, m_busy, done, m_done, handover_cnt, m_cnt);
            end
        end
        total++;
        if (bc != 3 + B || dc != 1 || handover_cnt !== 16'd2) begin
            bad++;
            $display("FAIL restart_summary busy_cycles=%0d done=%0d cnt=%0d want 11 1 2", bc, dc, handover_cnt);
        end
    endtask

    task automatic test_simultaneous();
        int b0 = 0, b37 = 0, both_done = 0;
        pin_sel[0*W +: W]  = 4'd3;
        pin_sel[37*W +: W] = 4'd5;
        for (int c = 0; c < 12; c++) begin
            rand_mux();
            tick();
            b0  += int'(busy[0]);
            b37 += int'(busy[37]);
            both_done += int'(done[0] & done[37]);
            total++;
            if ({pad_out, pad_oeb, busy, done} !== {m_out, m_oeb, m_busy, m_done} || handover_cnt !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL simultaneous c=%0d out=%h/%h oeb=%h/%h busy=%h/%h done=%h/%h cnt=%0d/%0d", c, pad_out, m_out, pad_oeb, m_oeb, busy, m_busy, done, m_done, handover_cnt, m_cnt);
            end
        end
        total++;
        if (b0 != B || b37 != B || both_done != 1 || handover_cnt !== 16'd3) begin
            bad++;
            $display("FAIL simultaneous_summary busy0=%0d busy37=%0d done_both=%0d cnt=%0d want 8 8 1 3", b0, b37, both_done, handover_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int bc = 0, dc = 0;
        pin_sel[9*W +: W] = 4'd6;
        for (int c = 0; c < 14; c++) begin
            if (c == 2) pin_sel[9*W +: W] = 4'd0;
            rand_mux();
            tick();
            bc += int'(busy[9]);
            dc += int'(done[9]);
        end
        total++;
        if (bc != 2 + B || dc != 1 || handover_cnt !== 16'd4) begin
            bad++;
            $display("FAIL back_to_back busy_cycles=%0d done=%0d cnt=%0d want 10 1 4", bc, dc, handover_cnt);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(7) == 0) pin_sel[$urandom_range(N-1)*W +: W] = 4'($urandom());
            rand_mux();
            tick();
            total++;
            if ({pad_out, pad_oeb, busy, done} !== {m_out, m_oeb, m_busy, m_done} || handover_cnt !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL random c=%0d out=%h/%h oeb=%h/%h busy=%h/%h done=%h/%h cnt=%0d/%0d", c, pad_out, m_out, pad_oeb, m_oeb, busy, m_busy, done, m_done, handover_cnt, m_cnt);
            end
        end
        settle(B + 4);
    endtask

    task automatic test_reset_mid();
        int bc = 0, dc = 0;
        pin_sel[7*W +: W] = pin_sel[7*W +: W] + 4'd1;
        for (int c = 0; c < 4; c++) begin
            rand_mux();
            tick();
            dc += int'(done[7]);
        end
        total++;
        if (busy[7] !== 1'b1 || pad_oeb[7] !== 1'b1) begin
            bad++;
            $display("FAIL mid_blank busy7=%b oeb7=%b want 1 1", busy[7], pad_oeb[7]);
        end
        nrst = 1'b0;
        model_reset();
        #1;
        total++;
        if (pad_oeb !== {N{1'b1}} || pad_out !== '0 || busy !== '0 || done !== '0 || handover_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_abort oeb=%h out=%h busy=%h done=%h cnt=%0d want oeb=all1 rest=0", pad_oeb, pad_out, busy, done, handover_cnt);
        end
        pin_sel = '0;
        pin_sel[7*W +: W] = 4'd2;
        @(negedge clk);
        nrst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            rand_mux();
            tick();
            bc += int'(busy[7]);
            dc += int'(done[7]);
            total++;
            if ({pad_out, pad_oeb, busy, done} !== {m_out, m_oeb, m_busy, m_done} || handover_cnt !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL reset_reblank c=%0d out=%h/%h oeb=%h/%h busy=%h/%h done=%h/%h cnt=%0d/%0d", c, pad_out, m_out, pad_oeb, m_oeb, busy, m_busy, done, m_done, handover_cnt, m_cnt);
            end
        end
        total++;
        if (bc != B || dc != 1 || handover_cnt !== 16'd1) begin
            bad++;
            $display("FAIL reset_reblank_summary busy_cycles=%0d done=%0d cnt=%0d want 8 1 1", bc, dc, handover_cnt);
        end
    endtask

    task automatic test_saturate();
        int t = 0;
        settle(B + 4);
        // Rotating over ten pins gives one fresh IDLE->BLANK entry on every edge.
        while (m_cnt < 65534 && t < 70000) begin
            pin_sel[(t % 10)*W] = ~pin_sel[(t % 10)*W];
            tick();
            t++;
        end
        total++;
        if (handover_cnt !== 16'hFFFE) begin
            bad++;
            $display("FAIL sat_preload cnt=%h want fffe", handover_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            pin_sel[(t % 10)*W] = ~pin_sel[(t % 10)*W];
            tick();
            t++;
        end
        total++;
        if (handover_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_reach cnt=%h want ffff", handover_cnt);
        end
        for (int k = 0; k < 12; k++) begin
            pin_sel[(t % 10)*W] = ~pin_sel[(t % 10)*W];
            tick();
            t++;
        end
        total++;
        if (handover_cnt !== 16'hFFFF || busy !== m_busy) begin
            bad++;
            $display("FAIL sat_hold cnt=%h want ffff busy=%h want %h", handover_cnt, busy, m_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_restart();
        test_simultaneous();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_handover.md
GPIO_HANDOVER -- requirements
Module: gpio_handover

Interface
REQ-001 Parameter NUM_PINS, default 38: number of GPIO pins handled.
REQ-002 Parameter SEL_W, default 4: width of each pin's owner-select code (up to 16 owners).
REQ-003 Parameter BLANK_CYCLES, default 8: tristate hold length on owner change; legal range 1..255.
REQ-004 clk  input  1: single clock; all state SHALL be updated on its rising edge.
REQ-005 nrst  input  1: reset, asynchronous and active-low.
REQ-006 pin_sel  input  NUM_PINS*SEL_W: owner code per pin, pin i at bits [i*SEL_W +: SEL_W], from the GPIO control register block.
REQ-007 mux_out  input  NUM_PINS: muxed pin output data from the GPIO control block.
REQ-008 mux_oeb  input  NUM_PINS: muxed active-low output enable from the GPIO control block.
REQ-009 pad_out  output  NUM_PINS: registered pad output data.
REQ-010 pad_oeb  output  NUM_PINS: registered active-low pad output enable.
REQ-011 busy  output  NUM_PINS: pin i is in BLANK state.
REQ-012 done  output  NUM_PINS: one-cycle pulse, pin i has left BLANK.
REQ-013 handover_cnt  output  16: saturating count of handover events.

Function
REQ-014 Each pin SHALL have an independent FSM with states IDLE and BLANK, a registered copy sel_q of its select code, and an 8-bit down-counter cnt.
REQ-015 A change event for pin i SHALL occur at an edge where pin_sel[i] != sel_q[i].
REQ-016 IDLE with change event: next state BLANK, cnt <= BLANK_CYCLES-1, sel_q <= pin_sel[i].
REQ-017 BLANK with change event: stay in BLANK, reload cnt <= BLANK_CYCLES-1, sel_q <= pin_sel[i]; the blanking window restarts.
REQ-018 BLANK, no change event, cnt != 0: cnt decrements by 1.
REQ-019 BLANK, no change event, cnt == 0: next state IDLE, and done[i] SHALL be 1 for the following cycle only.
REQ-020 Resulting BLANK dwell after the last select change SHALL be exactly BLANK_CYCLES clock cycles.
REQ-021 At every edge, pad_oeb[i] SHALL be 1 if the next state of pin i is BLANK, otherwise mux_oeb[i].
REQ-022 At every edge, pad_out[i] SHALL be 0 if the next state of pin i is BLANK, otherwise mux_out[i].
REQ-023 Pass-through latency in IDLE SHALL be one cycle; there is no combinational path from any input to any output.
REQ-024 busy[i] SHALL equal (state == BLANK) and be registered.
REQ-025 handover_cnt SHALL increment by 1 at each edge where at least one pin enters BLANK from IDLE; simultaneous entries across pins count as one; restarts under REQ-017 do not count.
REQ-026 handover_cnt SHALL saturate at 16'hFFFF and not wrap.
REQ-027 Pins SHALL not interact; a change event on pin i SHALL not affect any other pin's state, counter or outputs.
REQ-028 A select change back to the original code while in BLANK SHALL still be treated as a change event (REQ-017).

Reset
REQ-029 While nrst = 0: all states IDLE, sel_q = 0, cnt = 0, pad_oeb = all 1, pad_out = 0, busy = 0, done = 0, handover_cnt = 0.
REQ-030 Assertion of nrst mid-BLANK SHALL abort blanking immediately, with no done pulse.
REQ-031 After nrst is released, any pin whose pin_sel is nonzero SHALL take a change event at the first edge and blank for BLANK_CYCLES cycles.

Verification
REQ-032 Reset release with pin_sel = 0, mux_oeb = 0, mux_out = 38'h15 -> one edge later pad_oeb = 0, pad_out = 38'h15, busy = 0, handover_cnt = 0.
REQ-033 Pin 3 select changes 0 -> 2 with BLANK_CYCLES = 8 -> pad_oeb[3] = 1 and busy[3] = 1 for exactly 8 cycles, then done[3] pulses once, pad_oeb[3] follows mux_oeb[3], handover_cnt = 1.
REQ-034 Pin 5 select changes 0 -> 1 at cycle 0, then 1 -> 4 at cycle 3 -> blanking ends 8 cycles after cycle 3, one done pulse, handover_cnt = 1.
REQ-035 Pins 0 and 37 change on the same edge -> both blank for 8 cycles, both done bits pulse together, handover_cnt = 1; all other pins pass through unchanged.
REQ-036 nrst asserted in cycle 4 of a blank on pin 7 -> outputs return immediately to reset values, no done pulse; after release with pin_sel[7] = 2, pin 7 blanks again for 8 cycles.
REQ-037 handover_cnt preloaded to 16'hFFFE by forcing 65534 events, then 3 more events -> handover_cnt = 16'hFFFF and it stays there.
